// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Scan scheduler for a multiplexed 7-segment display.
//
// It holds a NUM_DIGITS-digit hex value and lights one digit at a time. Each
// digit is preceded by a blanking gap in which all commons are off. New values
// arrive through a valid/ready handshake into a pending slot. The slot moves to
// the displayed (active) register only at a frame boundary, so a frame never
// shows a mix of old and new digits.
//
// Ports
//   i_clk          system clock
//   i_rstn         asynchronous active-low reset
//   i_enable       scan enable; low forces the display off (IDLE)
//   i_load_valid   new display value offered
//   i_load_data    hex value; nibble k = digit k, digit 0 = LSB
//   o_load_ready   pending slot free
//   o_bcd_data     code to the segment decoder: {1'b0, nibble}
//   o_seg_com      one-hot digit common; bit k = digit k
//   o_frame_done   one-cycle pulse after the last digit of a full frame
//
// Optional feature
//   SEG7_LZ_BLANK_EN  when defined, leading-zero digits (every nibble from the
//                     current digit up to the top digit is zero) keep their
//                     common off during SHOW. Digit 0 is always lit.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL_CYC  = 50000,
   parameter int BLANK_CYC  = 1000
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_enable,
   input  logic                    i_load_valid,
   input  logic [4*NUM_DIGITS-1:0] i_load_data,
   output logic                    o_load_ready,
   output logic [4:0]              o_bcd_data,
   output logic [7:0]              o_seg_com,
   output logic                    o_frame_done
);

   localparam int DATA_W  = 4 * NUM_DIGITS;
   localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
   localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [DIG_W-1:0]   digit_reg, digit_next;
   logic [DATA_W-1:0]  active_reg, active_next;
   logic [DATA_W-1:0]  pending_reg, pending_next;
   logic               pending_valid_reg, pending_valid_next;
   logic               load_ready_reg, load_ready_next;
   logic [4:0]         bcd_reg, bcd_next;
   logic [7:0]         seg_com_reg, seg_com_next;
   logic               frame_done_reg, frame_done_next;

   logic               load_accept;
   logic               frame_end;
   logic               digit_lit;

`ifdef SEG7_LZ_BLANK_EN
   // upper_zero[k]: nibbles k..NUM_DIGITS-1 of the active value are all zero
   logic [NUM_DIGITS-1:0] upper_zero;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
      assign upper_zero[gi] = ~|active_reg[DATA_W-1:4*gi];
   end

   // Active only changes when entering BLANK, so it is stable across SHOW entry
   assign digit_lit = (digit_next == '0) || !upper_zero[digit_next];
`else
   assign digit_lit = 1'b1;
`endif

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_reg         <= ST_IDLE;
         cnt_reg           <= '0;
         digit_reg         <= '0;
         active_reg        <= '0;
         pending_reg       <= '0;
         pending_valid_reg <= 1'b0;
         load_ready_reg    <= 1'b1;
         bcd_reg           <= '0;
         seg_com_reg       <= '0;
         frame_done_reg    <= 1'b0;
      end else begin
         state_reg         <= state_next;
         cnt_reg           <= cnt_next;
         digit_reg         <= digit_next;
         active_reg        <= active_next;
         pending_reg       <= pending_next;
         pending_valid_reg <= pending_valid_next;
         load_ready_reg    <= load_ready_next;
         bcd_reg           <= bcd_next;
         seg_com_reg       <= seg_com_next;
         frame_done_reg    <= frame_done_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      cnt_next           = cnt_reg;
      digit_next         = digit_reg;
      active_next        = active_reg;
      pending_next       = pending_reg;
      pending_valid_next = pending_valid_reg;
      frame_end          = 1'b0;
      bcd_next           = '0;
      seg_com_next       = '0;

      // load_ready_reg is only high when the slot is empty
      load_accept = i_load_valid && load_ready_reg;

      case (state_reg)
         ST_IDLE: begin
            cnt_next   = '0;
            digit_next = '0;
            if (i_enable) begin
               state_next = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (cnt_reg == BLANK_LAST) begin
               state_next = ST_SHOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_SHOW: begin
            if (cnt_reg == DWELL_LAST) begin
               state_next = ST_BLANK;
               cnt_next   = '0;
               if (digit_reg == DIGIT_LAST) begin
                  frame_end  = 1'b1;
                  digit_next = '0;
               end else begin
                  digit_next = digit_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            digit_next = '0;
         end
      endcase

      // Disable abandons the partial frame: no pulse, no value swap
      if (!i_enable) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
         digit_next = '0;
         frame_end  = 1'b0;
      end

      if (frame_end && pending_valid_reg) begin
         active_next        = pending_reg;
         pending_valid_next = 1'b0;
      end

      // An accept can never coincide with a swap: accept needs an empty slot
      if (load_accept) begin
         pending_next       = i_load_data;
         pending_valid_next = 1'b1;
      end

      // Drops with the accept, rises one cycle after the slot is emptied
      load_ready_next = load_accept ? 1'b0 : !pending_valid_reg;

      frame_done_next = frame_end;

      // Outputs follow the next state so they line up with it cycle for cycle
      if (state_next == ST_SHOW) begin
         bcd_next = {1'b0, active_reg[4*digit_next +: 4]};
         if (digit_lit) begin
            seg_com_next = 8'(1) << digit_next;
         end
      end
   end

   assign o_load_ready = load_ready_reg;
   assign o_bcd_data   = bcd_reg;
   assign o_seg_com    = seg_com_reg;
   assign o_frame_done = frame_done_reg;

endmodule
